// File: rtl/multi_producer_ctrl_pkg.sv
// Shared definitions for multi_producer_ctrl: state encoding, status bit positions,
// default parameter values and the state-to-status decode.
package multi_producer_ctrl_pkg;

    localparam int unsigned NCH_DEF       = 4;
    localparam int unsigned DW_DEF        = 16;
    localparam int unsigned DRAIN_TMO_DEF = 1024;
    localparam int unsigned STATUS_W      = 5;

    localparam int unsigned ST_BIT_IDLE  = 0;
    localparam int unsigned ST_BIT_COMM  = 1;
    localparam int unsigned ST_BIT_WAIT  = 2;
    localparam int unsigned ST_BIT_DRAIN = 3;
    localparam int unsigned ST_BIT_ERR   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COMM  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // One-hot status word for a given state
    function automatic logic [STATUS_W-1:0] state_to_status(input state_e s);
        logic [STATUS_W-1:0] v;
        v = '0;
        case (s)
            ST_IDLE:  v[ST_BIT_IDLE]  = 1'b1;
            ST_COMM:  v[ST_BIT_COMM]  = 1'b1;
            ST_WAIT:  v[ST_BIT_WAIT]  = 1'b1;
            ST_DRAIN: v[ST_BIT_DRAIN] = 1'b1;
            ST_ERR:   v[ST_BIT_ERR]   = 1'b1;
            default:  v[ST_BIT_IDLE]  = 1'b1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/multi_producer_ctrl_pulse_rise.sv
// Rising-edge detector. The armed flag keeps a level held high through reset
// from being seen as a fresh edge until it has gone low and high again.
module pulse_rise (
    input  logic clock,
    input  logic reset,
    input  logic sig,
    output logic rise_c
);

    logic prev;
    logic armed;

    always_ff @(posedge clock) begin
        if (reset) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= sig;
            armed <= 1'b1;
        end
    end

    assign rise_c = sig & ~prev & armed;

endmodule

// File: rtl/multi_producer_ctrl.sv
// Multi-producer buffer write controller: arbitrates one producer channel per session,
// forwards its words to the buffer. Optional DRAIN watchdog under DRAIN_TIMEOUT_EN.
module multi_producer_ctrl
    import multi_producer_ctrl_pkg::*;
#(
    parameter int unsigned NCH       = NCH_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned DRAIN_TMO = DRAIN_TMO_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NCH-1:0]           start,
    input  logic                     stop,
    input  logic [NCH-1:0]           prod_valid,
    input  logic [NCH*DW-1:0]        prod_data,
    input  logic                     buf_full,
    input  logic                     buf_empty,
    input  logic                     rd_valid,
    output logic [NCH-1:0]           prod_en,
    output logic                     wr_en,
    output logic [DW-1:0]            wr_data,
    output logic                     parity,
    output logic [$clog2(NCH)-1:0]   active_ch,
    output logic [STATUS_W-1:0]      status
);

    localparam int unsigned AW = $clog2(NCH);

    if (NCH < 2 || NCH > 8) begin : g_bad_nch
        $error("multi_producer_ctrl: NCH must be 2..8");
    end
    if (DW < 1 || DW > 32) begin : g_bad_dw
        $error("multi_producer_ctrl: DW must be 1..32");
    end
    if (DRAIN_TMO < 2) begin : g_bad_tmo
        $error("multi_producer_ctrl: DRAIN_TMO must be at least 2");
    end

    logic [NCH-1:0] start_rise_c;
    logic           stop_rise_c;

    for (genvar k = 0; k < NCH; k++) begin : g_start_edge
        pulse_rise u_start_edge (
            .clock  (clock),
            .reset  (reset),
            .sig    (start[k]),
            .rise_c (start_rise_c[k])
        );
    end

    pulse_rise u_stop_edge (
        .clock  (clock),
        .reset  (reset),
        .sig    (stop),
        .rise_c (stop_rise_c)
    );

    state_e         state;
    state_e         state_nxt;
    logic [AW-1:0]  first_ch;
    logic [AW-1:0]  ch_sel;
    logic           any_start;
    logic           sel_valid;
    logic [DW-1:0]  sel_data;
    logic           wr_go_c;

    // Lowest-index start rise wins
    always_comb begin
        first_ch = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (start_rise_c[k]) first_ch = AW'(k);
        end
    end

    assign any_start = |start_rise_c;
    assign ch_sel    = (state == ST_IDLE && any_start) ? first_ch : active_ch;

    // Active channel's valid strobe and data slice
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (active_ch == AW'(k)) begin
                sel_valid = prod_valid[k];
                sel_data  = prod_data[k*DW +: DW];
            end
        end
    end

`ifdef DRAIN_TIMEOUT_EN
    localparam int unsigned TW = (DRAIN_TMO > 1) ? $clog2(DRAIN_TMO) : 1;
    localparam int unsigned SW = STATUS_W;

    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit_c;

    assign tmo_hit_c = (tmo_cnt == TW'(DRAIN_TMO - 1));

    // Cycles spent in DRAIN; held at zero elsewhere so every entry starts fresh
    always_ff @(posedge clock) begin
        if (reset || state != ST_DRAIN) tmo_cnt <= '0;
        else                            tmo_cnt <= tmo_cnt + TW'(1);
    end

    logic [SW-1:0] status_q;
    assign status = status_q;
`else
    localparam int unsigned SW = STATUS_W - 1;

    logic [SW-1:0] status_q;
    assign status = {1'b0, status_q};
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (any_start) state_nxt = ST_COMM;
            end
            ST_COMM: begin
                if (stop_rise_c)   state_nxt = ST_DRAIN;
                else if (buf_full) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (stop_rise_c)    state_nxt = ST_DRAIN;
                else if (!buf_full) state_nxt = ST_COMM;
            end
            ST_DRAIN: begin
                if (buf_empty && !rd_valid) state_nxt = ST_IDLE;
`ifdef DRAIN_TIMEOUT_EN
                else if (tmo_hit_c)         state_nxt = ST_ERR;
`endif
            end
            ST_ERR: begin
`ifdef DRAIN_TIMEOUT_EN
                if (stop_rise_c) state_nxt = ST_IDLE;
`else
                state_nxt = ST_IDLE;
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A stop rise in COMM suppresses the write so nothing lands once DRAIN begins
    assign wr_go_c = (state == ST_COMM) && !stop_rise_c && sel_valid && !buf_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            status_q  <= SW'(state_to_status(ST_IDLE));
            active_ch <= '0;
            prod_en   <= '0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            parity    <= 1'b0;
        end else begin
            state     <= state_nxt;
            status_q  <= SW'(state_to_status(state_nxt));
            active_ch <= ch_sel;
            prod_en   <= (state_nxt == ST_COMM) ? (NCH'(1) << ch_sel) : '0;
            wr_en     <= wr_go_c;
            if (wr_go_c) begin
                wr_data <= sel_data;
                parity  <= ^sel_data;
            end
        end
    end

endmodule

// File: tb/tb_multi_producer_ctrl.sv
// Scoreboard bench for multi_producer_ctrl (NCH=4, DW=16, DRAIN_TMO=8); the DRAIN
// timeout section follows DRAIN_TIMEOUT_EN.
module tb_multi_producer_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  start;
    logic        stop;
    logic [3:0]  prod_valid;
    logic [63:0] prod_data;
    logic        buf_full;
    logic        buf_empty;
    logic        rd_valid;
    logic [3:0]  prod_en;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        parity;
    logic [1:0]  active_ch;
    logic [4:0]  status;

    typedef struct packed {
        logic [15:0] data;
        logic        par;
        logic [1:0]  ch;
    } exp_t;

    exp_t exp_q[$];
    int   errors  = 0;
    int   checks  = 0;
    int   nwrites = 0;

    localparam logic [4:0] S_IDLE  = 5'b00001;
    localparam logic [4:0] S_COMM  = 5'b00010;
    localparam logic [4:0] S_WAIT  = 5'b00100;
    localparam logic [4:0] S_DRAIN = 5'b01000;
    localparam logic [4:0] S_ERR   = 5'b10000;

    multi_producer_ctrl #(.NCH(4), .DW(16), .DRAIN_TMO(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .prod_valid (prod_valid),
        .prod_data  (prod_data),
        .buf_full   (buf_full),
        .buf_empty  (buf_empty),
        .rd_valid   (rd_valid),
        .prod_en    (prod_en),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .parity     (parity),
        .active_ch  (active_ch),
        .status     (status)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_status"},    32'(status),    32'(S_IDLE));
        chk({tag, "_prod_en"},   32'(prod_en),   32'h0);
        chk({tag, "_wr_en"},     32'(wr_en),     32'h0);
        chk({tag, "_wr_data"},   32'(wr_data),   32'h0);
        chk({tag, "_parity"},    32'(parity),    32'h0);
        chk({tag, "_active_ch"}, 32'(active_ch), 32'h0);
    endtask

    // Present one word on channel ch for a single cycle and book the expected write
    task automatic issue_word(input int ch, input logic [15:0] d, input logic par);
        prod_data[ch*16 +: 16] = d;
        prod_valid[ch]         = 1'b1;
        exp_q.push_back('{data: d, par: par, ch: 2'(ch)});
        tick;
        prod_valid = '0;
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; start = '0; stop = 1'b0; prod_valid = '0; prod_data = '0;
        buf_full = 1'b0; buf_empty = 1'b0; rd_valid = 1'b0;

        // Monitor: every buffer write must match the oldest booked expectation
        fork
            forever begin
                @(negedge clock);
                if (!reset && wr_en) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got wr_data=%0h, required no write", wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mon_wr_data",   32'(wr_data),   32'(e.data));
                        chk("mon_parity",    32'(parity),    32'(e.par));
                        chk("mon_active_ch", 32'(active_ch), 32'(e.ch));
                        nwrites++;
                    end
                end
            end
        join_none

        tick; tick;
        chk_reset_outputs("reset");
        reset = 1'b0;
        tick;
        chk("idle_after_reset", 32'(status), 32'(S_IDLE));

        // Single channel session on channel 2
        start[2] = 1'b1;
        tick;
        chk("ch2_status",    32'(status),    32'(S_COMM));
        chk("ch2_active_ch", 32'(active_ch), 32'd2);
        chk("ch2_prod_en",   32'(prod_en),   32'b0100);
        chk("ch2_no_wr_yet", 32'(wr_en),     32'h0);
        prod_data[0 +: 16] = 16'hDEAD;
        prod_valid[0]      = 1'b1;
        issue_word(2, 16'h0005, 1'b0);
        chk("ch2_wr_en_lat1", 32'(wr_en),   32'h1);
        chk("ch2_wr_data",    32'(wr_data), 32'h0005);
        chk("ch2_parity",     32'(parity),  32'h0);
        tick;
        chk("ch2_wr_en_drop", 32'(wr_en),   32'h0);
        chk("ch2_data_held",  32'(wr_data), 32'h0005);
        issue_word(2, 16'h0007, 1'b1);
        tick;

        // Backpressure: COMM -> WAIT -> COMM
        buf_full = 1'b1;
        prod_valid[2] = 1'b1;
        prod_data[32 +: 16] = 16'hFFFF;
        tick;
        chk("wait_status",  32'(status),  32'(S_WAIT));
        chk("wait_prod_en", 32'(prod_en), 32'h0);
        chk("wait_wr_en",   32'(wr_en),   32'h0);
        tick;
        chk("wait_hold",    32'(status),  32'(S_WAIT));
        buf_full = 1'b0;
        prod_valid = '0;
        tick;
        chk("resume_status",  32'(status),  32'(S_COMM));
        chk("resume_prod_en", 32'(prod_en), 32'b0100);

        // stop rise together with buf_full goes to DRAIN; a start rise there is discarded
        stop = 1'b1;
        buf_full = 1'b1;
        prod_valid[2] = 1'b1;
        tick;
        prod_valid = '0;
        chk("drain_status",  32'(status),  32'(S_DRAIN));
        chk("drain_wr_en",   32'(wr_en),   32'h0);
        chk("drain_prod_en", 32'(prod_en), 32'h0);
        start[0] = 1'b1;
        buf_empty = 1'b1;
        rd_valid  = 1'b1;
        tick;
        chk("drain_rd_valid_hold", 32'(status), 32'(S_DRAIN));
        rd_valid = 1'b0;
        tick;
        chk("drain_to_idle", 32'(status), 32'(S_IDLE));
        tick;
        chk("start_in_drain_discarded", 32'(status), 32'(S_IDLE));

        // Simultaneous rises: lowest index wins; later rise in COMM ignored
        start = '0; stop = 1'b0; buf_full = 1'b0; buf_empty = 1'b0;
        tick;
        start = 4'b1010;
        tick;
        chk("arb_status",    32'(status),    32'(S_COMM));
        chk("arb_active_ch", 32'(active_ch), 32'd1);
        chk("arb_prod_en",   32'(prod_en),   32'b0010);
        start = 4'b1011;
        tick;
        chk("late_start_active_ch", 32'(active_ch), 32'd1);
        chk("late_start_prod_en",   32'(prod_en),   32'b0010);
        issue_word(1, 16'h1234, 1'b1);
        tick;

        // stop rise in WAIT
        buf_full = 1'b1;
        tick;
        chk("wait2_status", 32'(status), 32'(S_WAIT));
        stop = 1'b1;
        tick;
        chk("wait_stop_drain", 32'(status), 32'(S_DRAIN));
        buf_full = 1'b0; buf_empty = 1'b1; rd_valid = 1'b0;
        tick;
        chk("wait_stop_idle", 32'(status), 32'(S_IDLE));

        // Reset in WAIT with start[0] held high
        start = '0; stop = 1'b0; buf_empty = 1'b0;
        tick;
        start[0] = 1'b1;
        tick;
        chk("ch0_active_ch", 32'(active_ch), 32'd0);
        chk("ch0_prod_en",   32'(prod_en),   32'b0001);
        buf_full = 1'b1;
        tick;
        chk("ch0_wait", 32'(status), 32'(S_WAIT));
        reset = 1'b1;
        prod_valid[0] = 1'b1;
        tick;
        chk_reset_outputs("rst_in_wait");
        reset = 1'b0; prod_valid = '0; buf_full = 1'b0;
        tick; tick; tick;
        chk("held_start_no_trigger", 32'(status), 32'(S_IDLE));
        start[0] = 1'b0;
        tick;
        start[0] = 1'b1;
        tick;
        chk("retrigger_status",  32'(status),  32'(S_COMM));
        chk("retrigger_prod_en", 32'(prod_en), 32'b0001);

        // Reset drops an in-flight write
        prod_data[0 +: 16] = 16'h4242;
        prod_valid[0] = 1'b1;
        reset = 1'b1;
        tick;
        chk("inflight_wr_en",   32'(wr_en),   32'h0);
        chk("inflight_wr_data", 32'(wr_data), 32'h0);
        reset = 1'b0; prod_valid = '0; start = '0;
        tick;
        start[0] = 1'b1;
        tick;
        chk("tmo_setup_comm", 32'(status), 32'(S_COMM));

        // DRAIN with the buffer never emptying
        stop = 1'b1; buf_empty = 1'b0; rd_valid = 1'b0;
        tick;
        chk("tmo_drain_entry", 32'(status), 32'(S_DRAIN));
        repeat (7) tick;
        chk("tmo_drain_7", 32'(status), 32'(S_DRAIN));
        tick;
`ifdef DRAIN_TIMEOUT_EN
        chk("tmo_err", 32'(status), 32'(S_ERR));
        buf_empty = 1'b1;
        tick;
        chk("err_sticky", 32'(status), 32'(S_ERR));
        stop = 1'b0;
        tick;
        stop = 1'b1;
        tick;
        chk("err_stop_idle", 32'(status), 32'(S_IDLE));
`else
        chk("no_tmo_drain_8", 32'(status), 32'(S_DRAIN));
        repeat (20) tick;
        chk("no_tmo_drain_28", 32'(status), 32'(S_DRAIN));
        buf_empty = 1'b1;
        tick;
        chk("no_tmo_idle", 32'(status), 32'(S_IDLE));
`endif

        tick; tick;
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        chk("write_count",    32'(nwrites),      32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
